// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite response encodings for peripheral slaves.
// No ports; imported by the front end and by peripheral cores.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/timer_pkg.sv
// timer_pkg: register map, CTRL bit layout and byte-strobe helper for the
// AXI4-Lite down-counter timer. No ports.
package timer_pkg;

    localparam logic [31:0] OFF_CTRL   = 32'h0000_0000;
    localparam logic [31:0] OFF_LOAD   = 32'h0000_0004;
    localparam logic [31:0] OFF_COUNT  = 32'h0000_0008;
    localparam logic [31:0] OFF_STATUS = 32'h0000_000C;

    localparam int EN_BIT = 0;
    localparam int AR_BIT = 1;
    localparam int IE_BIT = 2;

    // Field order places en at bit 0, matching EN_BIT/AR_BIT/IE_BIT.
    typedef struct packed {
        logic ie;
        logic ar;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_slave_fe.sv
// axi_lite_slave_fe: reusable AXI4-Lite slave handshake front end.
// Holds AW and W independently, issues one write strobe when both are
// available, and owns the B and R response registers.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   s_aw*/s_w*/s_b*/s_ar*/s_r*     AXI4-Lite slave channels (address AW bits)
//   o_wr_en/addr/data/strb         single-cycle register write request
//   i_wr_err                       write target invalid -> SLVERR
//   o_rd_en/o_rd_addr              read request (address is combinational)
//   i_rd_data/i_rd_err             read data/error for o_rd_addr, same cycle
module axi_lite_slave_fe
    import axi_lite_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] s_awaddr,
    input  logic          s_awvalid,
    output logic          s_awready,
    input  logic [31:0]   s_wdata,
    input  logic [3:0]    s_wstrb,
    input  logic          s_wvalid,
    output logic          s_wready,
    output logic [1:0]    s_bresp,
    output logic          s_bvalid,
    input  logic          s_bready,
    input  logic [AW-1:0] s_araddr,
    input  logic          s_arvalid,
    output logic          s_arready,
    output logic [31:0]   s_rdata,
    output logic [1:0]    s_rresp,
    output logic          s_rvalid,
    input  logic          s_rready,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [31:0]   o_wr_data,
    output logic [3:0]    o_wr_strb,
    input  logic          i_wr_err,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    input  logic [31:0]   i_rd_data,
    input  logic          i_rd_err
);

    logic          r_aw_held;
    logic [AW-1:0] r_aw_addr;
    logic          r_w_held;
    logic [31:0]   r_w_data;
    logic [3:0]    r_w_strb;
    logic          r_bvalid;
    logic [1:0]    r_bresp;
    logic          r_rvalid;
    logic [31:0]   r_rdata;
    logic [1:0]    r_rresp;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_wr_fire;

    assign s_awready = !r_aw_held && !r_bvalid;
    assign s_wready  = !r_w_held && !r_bvalid;
    assign s_arready = !r_rvalid;

    assign w_aw_hs = s_awvalid && s_awready;
    assign w_w_hs  = s_wvalid && s_wready;
    assign w_ar_hs = s_arvalid && s_arready;

    // Each half is available if already held or handshaking this edge.
    assign w_wr_fire = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    assign o_wr_en   = w_wr_fire;
    assign o_wr_addr = r_aw_held ? r_aw_addr : s_awaddr;
    assign o_wr_data = r_w_held ? r_w_data : s_wdata;
    assign o_wr_strb = r_w_held ? r_w_strb : s_wstrb;

    assign o_rd_en   = w_ar_hs;
    assign o_rd_addr = s_araddr;

    assign s_bvalid = r_bvalid;
    assign s_bresp  = r_bresp;
    assign s_rvalid = r_rvalid;
    assign s_rdata  = r_rdata;
    assign s_rresp  = r_rresp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_held <= 1'b0;
            r_aw_addr <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else if (w_wr_fire) begin
            // bvalid is necessarily low here: neither ready is high while it is set.
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= i_wr_err ? RESP_SLVERR : RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= s_awaddr;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_w_data <= s_wdata;
                r_w_strb <= s_wstrb;
            end
            if (r_bvalid && s_bready) r_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= i_rd_err ? 32'h0 : i_rd_data;
            r_rresp  <= i_rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (r_rvalid && s_rready) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_lite_timer.sv
// axi_lite_timer: AXI4-Lite peripheral with a 32-bit auto-reload down-counter.
// Registers: 0x00 CTRL (EN, AUTO_RELOAD, IRQ_EN), 0x04 LOAD, 0x08 COUNT (RO),
// 0x0C STATUS (W1C EXPIRED). Other offsets answer SLVERR.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   s_*            AXI4-Lite slave (address ADDR_W, data 32)
//   irq            level interrupt, EXPIRED & IRQ_EN
module axi_lite_timer
    import timer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEC_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic              irq
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("axi_lite_timer supports DATA_W = 32 only");
    end

    localparam logic [DEC_W-1:0] L_CTRL   = OFF_CTRL[DEC_W-1:0];
    localparam logic [DEC_W-1:0] L_LOAD   = OFF_LOAD[DEC_W-1:0];
    localparam logic [DEC_W-1:0] L_COUNT  = OFF_COUNT[DEC_W-1:0];
    localparam logic [DEC_W-1:0] L_STATUS = OFF_STATUS[DEC_W-1:0];

    ctrl_t       r_ctrl;
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic        r_expired;

    logic             w_wr_en;
    logic [DEC_W-1:0] w_wr_addr;
    logic [31:0]      w_wr_data;
    logic [3:0]       w_wr_strb;
    logic             w_wr_err;
    logic             w_rd_en;
    logic [DEC_W-1:0] w_rd_addr;
    logic [31:0]      w_rd_data;
    logic             w_rd_err;

    logic        w_wr_ctrl;
    logic        w_wr_load;
    logic        w_w1c;
    logic        w_expire;
    logic [31:0] w_new_load;

    // Upper address bits were already consumed by the crossbar routing.
    logic w_unused;
    assign w_unused = &{1'b0, s_awaddr[ADDR_W-1:DEC_W], s_araddr[ADDR_W-1:DEC_W], w_rd_en};

    axi_lite_slave_fe #(.AW(DEC_W)) u_fe (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_awaddr  (s_awaddr[DEC_W-1:0]),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr[DEC_W-1:0]),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .o_wr_en   (w_wr_en),
        .o_wr_addr (w_wr_addr),
        .o_wr_data (w_wr_data),
        .o_wr_strb (w_wr_strb),
        .i_wr_err  (w_wr_err),
        .o_rd_en   (w_rd_en),
        .o_rd_addr (w_rd_addr),
        .i_rd_data (w_rd_data),
        .i_rd_err  (w_rd_err)
    );

    // COUNT is read-only, so only three offsets accept writes.
    assign w_wr_err = !((w_wr_addr == L_CTRL) || (w_wr_addr == L_LOAD) ||
                        (w_wr_addr == L_STATUS));

    assign w_wr_ctrl  = w_wr_en && (w_wr_addr == L_CTRL) && w_wr_strb[0];
    assign w_wr_load  = w_wr_en && (w_wr_addr == L_LOAD);
    assign w_w1c      = w_wr_en && (w_wr_addr == L_STATUS) && w_wr_strb[0] && w_wr_data[0];
    assign w_new_load = apply_strb(r_load, w_wr_data, w_wr_strb);
    assign w_expire   = r_ctrl.en && (r_count == 32'h0);

    always_comb begin
        w_rd_data = 32'h0;
        w_rd_err  = 1'b0;
        case (w_rd_addr)
            L_CTRL:   w_rd_data = {29'h0, r_ctrl};
            L_LOAD:   w_rd_data = r_load;
            L_COUNT:  w_rd_data = r_count;
            L_STATUS: w_rd_data = {31'h0, r_expired};
            default:  w_rd_err  = 1'b1;
        endcase
    end

    // Later assignments take priority: bus writes override the counter, and
    // an expiry overrides a simultaneous W1C so the event is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl    <= '0;
            r_load    <= '0;
            r_count   <= '0;
            r_expired <= 1'b0;
        end else begin
            if (r_ctrl.en) begin
                if (r_count != 32'h0) r_count <= r_count - 32'h1;
                else if (r_ctrl.ar)   r_count <= r_load;
            end
            if (w_expire && !r_ctrl.ar) r_ctrl.en <= 1'b0;
            if (w_wr_ctrl) r_ctrl <= ctrl_t'(w_wr_data[IE_BIT:EN_BIT]);
            if (w_wr_load) begin
                r_load  <= w_new_load;
                r_count <= w_new_load;
            end
            if (w_w1c)    r_expired <= 1'b0;
            if (w_expire) r_expired <= 1'b1;
        end
    end

    assign irq = r_expired && r_ctrl.ie;

endmodule

// File: tb/tb_axi_lite_timer.sv
`timescale 1ns/1ps
module tb_axi_lite_timer;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [11:0] A_CTRL = 12'h000, A_LOAD = 12'h004, A_COUNT = 12'h008, A_STATUS = 12'h00C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b1;
    logic [31:0] s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b1;
    logic        irq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    axi_lite_timer #(.ADDR_W(32), .DATA_W(32), .DEC_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // Window base bits are randomised: only the low 12 bits may matter.
    function automatic logic [31:0] addr_of(input logic [11:0] off);
        return ($urandom & 32'hFFFF_F000) | {20'h0, off};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // AW and W together; returns at the edge after the write edge (B consumed
    // when bready=1). w_edge is the edge index on which the write took effect.
    task automatic axi_write(input logic [11:0] off, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int w_edge);
        logic aw_done, w_done, aw_ok, w_ok;
        int n;
        s_awaddr = addr_of(off); s_wdata = d; s_wstrb = s;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0; resp = 2'b11;
        while (!(aw_done && w_done) && n < 20) begin
            aw_ok = s_awready && s_awvalid;
            w_ok  = s_wready && s_wvalid;
            @(posedge clk); #1; n++;
            if (aw_ok) begin aw_done = 1'b1; s_awvalid = 1'b0; end
            if (w_ok)  begin w_done = 1'b1;  s_wvalid = 1'b0; end
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        w_edge = cyc;
        total++;
        if (!(aw_done && w_done) || s_bvalid !== 1'b1) begin
            bad++;
            $display("FAIL write_bvalid off=%h got bvalid=%b expected 1 after write edge", off, s_bvalid);
        end else begin
            resp = s_bresp;
        end
        if (s_bready) tick(1);
    endtask

    // r_edge is the AR handshake edge; data reflects state after edge r_edge-1.
    task automatic axi_read(input logic [11:0] off, output logic [31:0] data,
                            output logic [1:0] resp, output int r_edge);
        logic ok, done;
        int n;
        s_araddr = addr_of(off); s_arvalid = 1'b1;
        done = 1'b0; n = 0; data = 32'hDEAD_BEEF; resp = 2'b11;
        while (!done && n < 20) begin
            ok = s_arready;
            @(posedge clk); #1; n++;
            if (ok) done = 1'b1;
        end
        s_arvalid = 1'b0;
        r_edge = cyc;
        total++;
        if (!done || s_rvalid !== 1'b1) begin
            bad++;
            $display("FAIL read_rvalid off=%h got rvalid=%b expected 1 after AR edge", off, s_rvalid);
        end else begin
            data = s_rdata;
            resp = s_rresp;
        end
        if (s_rready) tick(1);
    endtask

    task automatic do_reset();
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        s_bready = 1'b1; s_rready = 1'b1;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        int e;
        logic [11:0] offs [4];
        offs = '{A_CTRL, A_LOAD, A_COUNT, A_STATUS};
        do_reset();
        total++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            bad++;
            $display("FAIL reset_ready got aw/w/ar=%b%b%b expected 111", s_awready, s_wready, s_arready);
        end
        total++;
        if ({s_bvalid, s_rvalid, irq, s_bresp, s_rresp} !== 7'b0 || s_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs got bvalid=%b rvalid=%b irq=%b bresp=%b rresp=%b rdata=%h expected all 0",
                     s_bvalid, s_rvalid, irq, s_bresp, s_rresp, s_rdata);
        end
        foreach (offs[i]) begin
            axi_read(offs[i], d, r, e);
            total++;
            if (d !== 32'h0 || r !== OKAY) begin
                bad++;
                $display("FAIL reset_read off=%h got data=%h resp=%b expected 0/OKAY", offs[i], d, r);
            end
        end
    endtask

    task automatic test_aw_before_w();
        logic [31:0] d;
        logic [1:0]  r;
        int e;
        s_awaddr = addr_of(A_LOAD); s_awvalid = 1'b1;
        tick(1);
        s_awvalid = 1'b0;
        total++;
        if (s_awready !== 1'b0 || s_bvalid !== 1'b0) begin
            bad++;
            $display("FAIL aw_held got awready=%b bvalid=%b expected 0/0", s_awready, s_bvalid);
        end
        tick(1);
        s_wdata = 32'h5; s_wstrb = 4'hF; s_wvalid = 1'b1;
        total++;
        if (s_wready !== 1'b1) begin
            bad++;
            $display("FAIL w_ready_before got wready=%b expected 1", s_wready);
        end
        tick(1);
        s_wvalid = 1'b0;
        total++;
        if (s_bvalid !== 1'b1 || s_bresp !== OKAY) begin
            bad++;
            $display("FAIL bvalid_after_w got bvalid=%b bresp=%b expected 1/OKAY", s_bvalid, s_bresp);
        end
        tick(1);
        total++;
        if (s_bvalid !== 1'b0) begin
            bad++;
            $display("FAIL b_handshake got bvalid=%b expected 0", s_bvalid);
        end
        axi_read(A_LOAD, d, r, e);
        total++;
        if (d !== 32'h5 || r !== OKAY) begin
            bad++;
            $display("FAIL split_load got %h/%b expected 00000005/OKAY", d, r);
        end
        axi_read(A_COUNT, d, r, e);
        total++;
        if (d !== 32'h5 || r !== OKAY) begin
            bad++;
            $display("FAIL split_count got %h/%b expected 00000005/OKAY", d, r);
        end
    endtask

    // Periodic behaviour: with count=L at the enable edge, the value k edges
    // later is L - (k mod (L+1)) and the first expiry lands on edge L+1.
    task automatic test_auto_reload();
        logic [31:0] d;
        logic [1:0]  r;
        int e, en_edge, h, k, L, first_x, second_x;
        for (int it = 0; it < 6; it++) begin
            L = (it == 0) ? 3 : int'($urandom_range(1, 7));
            axi_write(A_CTRL, 32'h0, 4'hF, r, e);
            axi_write(A_STATUS, 32'h1, 4'hF, r, e);
            axi_write(A_LOAD, 32'(L), 4'hF, r, e);
            axi_write(A_CTRL, 32'h7, 4'hF, r, en_edge);
            if (it == 0) begin
                first_x = -1;
                for (int n = 0; n < 40 && first_x < 0; n++) begin
                    if (irq === 1'b1) first_x = cyc;
                    else tick(1);
                end
                total++;
                if (first_x != en_edge + L + 1) begin
                    bad++;
                    $display("FAIL first_expiry got edge=%0d expected edge=%0d", first_x, en_edge + L + 1);
                end
                axi_write(A_STATUS, 32'h1, 4'hF, r, e);
                total++;
                if (irq !== 1'b0) begin
                    bad++;
                    $display("FAIL irq_clear got irq=%b expected 0", irq);
                end
                second_x = -1;
                for (int n = 0; n < 40 && second_x < 0; n++) begin
                    if (irq === 1'b1) second_x = cyc;
                    else tick(1);
                end
                total++;
                if (second_x != first_x + L + 1) begin
                    bad++;
                    $display("FAIL reload_period got edge=%0d expected edge=%0d", second_x, first_x + L + 1);
                end
            end else begin
                tick(int'($urandom_range(0, 12)));
                axi_read(A_COUNT, d, r, h);
                k = h - 1 - en_edge;
                total++;
                if (d !== 32'(L - (k % (L + 1)))) begin
                    bad++;
                    $display("FAIL count_value L=%0d k=%0d got %0d expected %0d", L, k, d, L - (k % (L + 1)));
                end
                axi_read(A_STATUS, d, r, h);
                k = h - 1 - en_edge;
                total++;
                if (d !== ((k >= L + 1) ? 32'h1 : 32'h0)) begin
                    bad++;
                    $display("FAIL status_value L=%0d k=%0d got %h expected %0d", L, k, d, k >= L + 1);
                end
                total++;
                if (irq !== ((cyc - en_edge) >= L + 1)) begin
                    bad++;
                    $display("FAIL irq_level L=%0d k=%0d got %b expected %0d", L, cyc - en_edge, irq, (cyc - en_edge) >= L + 1);
                end
            end
        end
        axi_write(A_CTRL, 32'h0, 4'hF, r, e);
        axi_write(A_STATUS, 32'h1, 4'hF, r, e);
    endtask

    task automatic test_one_shot();
        logic [31:0] d;
        logic [1:0]  r;
        int e, en_edge, w_edge;
        axi_write(A_LOAD, 32'h2, 4'hF, r, e);
        axi_write(A_CTRL, 32'h1, 4'hF, r, en_edge);
        tick(4);
        axi_read(A_CTRL, d, r, e);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL oneshot_ctrl got %h expected 00000000", d);
        end
        axi_read(A_COUNT, d, r, e);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL oneshot_count got %h expected 00000000", d);
        end
        axi_read(A_STATUS, d, r, e);
        total++;
        if (d !== 32'h1 || irq !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_status got status=%h irq=%b expected 1/0", d, irq);
        end
        axi_write(A_STATUS, 32'h1, 4'h0, r, e);
        axi_read(A_STATUS, d, r, e);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL w1c_nostrb got %h expected 00000001", d);
        end
        axi_write(A_STATUS, 32'h1, 4'hF, r, e);
        axi_read(A_STATUS, d, r, e);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL w1c_clear got %h expected 00000000", d);
        end
        // Land a W1C exactly on the expiry edge (enable edge + 3).
        axi_write(A_LOAD, 32'h2, 4'hF, r, e);
        axi_write(A_CTRL, 32'h1, 4'hF, r, en_edge);
        tick(en_edge + 2 - cyc);
        axi_write(A_STATUS, 32'h1, 4'hF, r, w_edge);
        total++;
        if (w_edge != en_edge + 3) begin
            bad++;
            $display("FAIL collide_timing got edge=%0d expected edge=%0d", w_edge, en_edge + 3);
        end
        axi_read(A_STATUS, d, r, e);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL collide_set_wins got %h expected 00000001", d);
        end
        axi_write(A_STATUS, 32'h1, 4'hF, r, e);
    endtask

    task automatic test_errors();
        logic [31:0] d, x, old_v, new_v, exp_v;
        logic [3:0]  s;
        logic [1:0]  r;
        int e;
        x = $urandom;
        axi_write(A_LOAD, x, 4'hF, r, e);
        axi_write(A_COUNT, 32'h1234, 4'hF, r, e);
        total++;
        if (r !== SLVERR) begin
            bad++;
            $display("FAIL count_write_resp got %b expected SLVERR", r);
        end
        axi_read(A_COUNT, d, r, e);
        total++;
        if (d !== x || r !== OKAY) begin
            bad++;
            $display("FAIL count_unchanged got %h/%b expected %h/OKAY", d, r, x);
        end
        axi_read(12'h040, d, r, e);
        total++;
        if (d !== 32'h0 || r !== SLVERR) begin
            bad++;
            $display("FAIL bad_read got %h/%b expected 00000000/SLVERR", d, r);
        end
        axi_write(12'h040, $urandom, 4'hF, r, e);
        total++;
        if (r !== SLVERR) begin
            bad++;
            $display("FAIL bad_write_resp got %b expected SLVERR", r);
        end
        axi_read(A_LOAD, d, r, e);
        total++;
        if (d !== x) begin
            bad++;
            $display("FAIL bad_write_nochange got %h expected %h", d, x);
        end
        axi_write(A_LOAD, 32'h0, 4'hF, r, e);
        axi_write(A_LOAD, 32'hAABB_CCDD, 4'h1, r, e);
        axi_read(A_LOAD, d, r, e);
        total++;
        if (d !== 32'h0000_00DD) begin
            bad++;
            $display("FAIL strb_lane0 got %h expected 000000DD", d);
        end
        for (int it = 0; it < 4; it++) begin
            old_v = $urandom; new_v = $urandom; s = 4'($urandom_range(0, 15));
            exp_v = old_v;
            for (int b = 0; b < 4; b++) if (s[b]) exp_v[b*8 +: 8] = new_v[b*8 +: 8];
            axi_write(A_LOAD, old_v, 4'hF, r, e);
            axi_write(A_LOAD, new_v, s, r, e);
            axi_read(A_LOAD, d, r, e);
            total++;
            if (d !== exp_v) begin
                bad++;
                $display("FAIL strb_load strb=%h got %h expected %h", s, d, exp_v);
            end
            axi_read(A_COUNT, d, r, e);
            total++;
            if (d !== exp_v) begin
                bad++;
                $display("FAIL strb_count strb=%h got %h expected %h", s, d, exp_v);
            end
        end
        axi_write(A_CTRL, 32'h7, 4'hE, r, e);
        axi_read(A_CTRL, d, r, e);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL ctrl_nostrb got %h expected 00000000", d);
        end
        axi_write(A_CTRL, 32'hFFFF_FFFC, 4'hF, r, e);
        axi_read(A_CTRL, d, r, e);
        total++;
        if (d !== 32'h4 || r !== OKAY) begin
            bad++;
            $display("FAIL ctrl_mask got %h/%b expected 00000004/OKAY", d, r);
        end
        axi_write(A_CTRL, 32'h0, 4'hF, r, e);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, a_val, b_val;
        logic [1:0]  r;
        int e;
        a_val = $urandom; b_val = $urandom;
        s_bready = 1'b0;
        s_awaddr = addr_of(A_LOAD); s_wdata = a_val; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        tick(1);
        s_wdata = b_val;
        for (int n = 0; n < 5; n++) begin
            total++;
            if (s_bvalid !== 1'b1 || s_bresp !== OKAY || s_awready !== 1'b0 || s_wready !== 1'b0) begin
                bad++;
                $display("FAIL b_backpressure cyc=%0d got bvalid=%b bresp=%b awready=%b wready=%b expected 1/OKAY/0/0",
                         n, s_bvalid, s_bresp, s_awready, s_wready);
            end
            tick(1);
        end
        s_bready = 1'b1;
        tick(1);
        total++;
        if (s_bvalid !== 1'b0 || s_awready !== 1'b1) begin
            bad++;
            $display("FAIL b_release got bvalid=%b awready=%b expected 0/1", s_bvalid, s_awready);
        end
        tick(1);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        total++;
        if (s_bvalid !== 1'b1) begin
            bad++;
            $display("FAIL second_write got bvalid=%b expected 1", s_bvalid);
        end
        tick(1);
        axi_read(A_LOAD, d, r, e);
        total++;
        if (d !== b_val) begin
            bad++;
            $display("FAIL second_write_data got %h expected %h", d, b_val);
        end

        axi_write(A_CTRL, 32'h6, 4'hF, r, e);
        s_rready = 1'b0;
        s_araddr = addr_of(A_CTRL); s_arvalid = 1'b1;
        tick(1);
        s_araddr = addr_of(A_LOAD);
        for (int n = 0; n < 5; n++) begin
            total++;
            if (s_rvalid !== 1'b1 || s_rdata !== 32'h6 || s_rresp !== OKAY || s_arready !== 1'b0) begin
                bad++;
                $display("FAIL r_backpressure cyc=%0d got rvalid=%b rdata=%h rresp=%b arready=%b expected 1/00000006/OKAY/0",
                         n, s_rvalid, s_rdata, s_rresp, s_arready);
            end
            tick(1);
        end
        s_rready = 1'b1;
        tick(1);
        total++;
        if (s_rvalid !== 1'b0 || s_arready !== 1'b1) begin
            bad++;
            $display("FAIL r_release got rvalid=%b arready=%b expected 0/1", s_rvalid, s_arready);
        end
        tick(1);
        s_arvalid = 1'b0;
        total++;
        if (s_rvalid !== 1'b1 || s_rdata !== b_val) begin
            bad++;
            $display("FAIL second_read got rvalid=%b rdata=%h expected 1/%h", s_rvalid, s_rdata, b_val);
        end
        tick(1);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, v;
        logic [1:0]  r;
        int e;
        logic [11:0] offs [4];
        offs = '{A_CTRL, A_LOAD, A_COUNT, A_STATUS};
        s_bready = 1'b0;
        s_awaddr = addr_of(A_LOAD); s_wdata = 32'h55; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        tick(1);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (s_bvalid !== 1'b0 || s_awready !== 1'b1) begin
            bad++;
            $display("FAIL async_reset_b got bvalid=%b awready=%b expected 0/1", s_bvalid, s_awready);
        end
        tick(2);
        s_bready = 1'b1;
        rst_n = 1'b1;
        tick(1);
        // Leave an AW held toward CTRL, then reset again: it must be dropped.
        s_awaddr = addr_of(A_CTRL); s_awvalid = 1'b1;
        tick(1);
        s_awvalid = 1'b0;
        #2 rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        total++;
        if (s_bvalid !== 1'b0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_outputs got bvalid=%b irq=%b expected 0/0", s_bvalid, irq);
        end
        foreach (offs[i]) begin
            axi_read(offs[i], d, r, e);
            total++;
            if (d !== 32'h0) begin
                bad++;
                $display("FAIL reset_mid_regs off=%h got %h expected 00000000", offs[i], d);
            end
        end
        v = $urandom | 32'h100;
        axi_write(A_LOAD, v, 4'hF, r, e);
        axi_read(A_LOAD, d, r, e);
        total++;
        if (d !== v) begin
            bad++;
            $display("FAIL post_reset_write got %h expected %h", d, v);
        end
        axi_read(A_CTRL, d, r, e);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL stale_aw_dropped got CTRL=%h expected 00000000", d);
        end
    endtask

    initial begin
        test_reset();
        test_aw_before_w();
        test_auto_reload();
        test_one_shot();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
